// File: rtl/brc_pkg.sv
// Shared types and helpers for the branch-comparator arbiter: funct3 codes and
// the branch-condition decode used on the granted request.
package brc_pkg;

    localparam int BR_OP_W = 3;
    localparam int XLEN    = 32;

    typedef enum logic [BR_OP_W-1:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_ILL2 = 3'b010,
        BR_ILL3 = 3'b011,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } br_op_e;

    // Returns {taken, err}; unused funct3 codes never resolve as taken.
    function automatic logic [1:0] br_decode(input logic [BR_OP_W-1:0] op,
                                             input logic less,
                                             input logic equal);
        logic [1:0] res;
        case (br_op_e'(op))
            BR_BEQ:          res = {equal, 1'b0};
            BR_BNE:          res = {~equal, 1'b0};
            BR_BLT, BR_BLTU: res = {less, 1'b0};
            BR_BGE, BR_BGEU: res = {~less, 1'b0};
            default:         res = 2'b01;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/brc.sv
// Branch comparator: equality plus signed/unsigned less-than of two operands.
module brc #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rs1,
    input  logic [WIDTH-1:0] i_rs2,
    input  logic             i_br_un,
    output logic             o_br_eq,
    output logic             o_br_lt
);

    assign o_br_eq = (i_rs1 == i_rs2);
    assign o_br_lt = i_br_un ? (i_rs1 < i_rs2) : ($signed(i_rs1) < $signed(i_rs2));

endmodule

// File: rtl/brc_rr_picker.sv
// Combinational round-robin priority encoder: first set request at or above
// ptr, wrapping around, is granted.
module brc_rr_picker #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    // Rotating search starting from the priority pointer
    always_comb begin
        int   j;
        logic found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end else begin
                j = j;
            end
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/brc_arbiter.sv
// Round-robin arbiter sharing one branch comparator across NUM_REQ requesters.
// Optional grant/stall statistics counters are enabled by BRC_ARB_STATS_EN.
module brc_arbiter
    import brc_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_REQ-1:0]       i_req_valid,
    output logic [NUM_REQ-1:0]       o_req_ready,
    input  logic [NUM_REQ*32-1:0]    i_req_rs1,
    input  logic [NUM_REQ*32-1:0]    i_req_rs2,
    input  logic [NUM_REQ*3-1:0]     i_req_op,
    input  logic [NUM_REQ*TAG_W-1:0] i_req_tag,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [IDX_W-1:0]         o_rsp_id,
    output logic [TAG_W-1:0]         o_rsp_tag,
    output logic                     o_rsp_taken,
`ifdef BRC_ARB_STATS_EN
    output logic [NUM_REQ*16-1:0]    o_grant_cnt,
    output logic [15:0]              o_stall_cnt,
`endif
    output logic                     o_rsp_err
);

    logic               rsp_valid_r;
    logic               rsp_taken_r;
    logic               rsp_err_r;
    logic [IDX_W-1:0]   rsp_id_r;
    logic [TAG_W-1:0]   rsp_tag_r;
    logic [IDX_W-1:0]   rr_ptr_r;

    logic               can_acc_s;
    logic [NUM_REQ-1:0] pick_req_s;
    logic [NUM_REQ-1:0] gnt_s;
    logic [IDX_W-1:0]   gnt_idx_s;
    logic               any_gnt_s;
    logic [31:0]        rs1_s;
    logic [31:0]        rs2_s;
    logic [BR_OP_W-1:0] op_s;
    logic [TAG_W-1:0]   tag_s;
    logic               eq_s;
    logic               lt_s;
    logic [1:0]         dec_s;

    assign can_acc_s  = !rsp_valid_r || i_rsp_ready;
    // Reset gating keeps ready low while i_rst is asserted, independent of state.
    assign pick_req_s = i_req_valid & {NUM_REQ{can_acc_s && !i_rst}};
    assign any_gnt_s  = |gnt_s;
    assign o_req_ready = gnt_s;

    brc_rr_picker #(.N(NUM_REQ), .IW(IDX_W)) u_picker (
        .req (pick_req_s),
        .ptr (rr_ptr_r),
        .gnt (gnt_s),
        .idx (gnt_idx_s)
    );

    assign rs1_s = i_req_rs1[int'(gnt_idx_s)*32 +: 32];
    assign rs2_s = i_req_rs2[int'(gnt_idx_s)*32 +: 32];
    assign op_s  = i_req_op[int'(gnt_idx_s)*BR_OP_W +: BR_OP_W];
    assign tag_s = i_req_tag[int'(gnt_idx_s)*TAG_W +: TAG_W];

    brc #(.WIDTH(XLEN)) u_brc (
        .i_rs1   (rs1_s),
        .i_rs2   (rs2_s),
        .i_br_un (op_s[1]),
        .o_br_eq (eq_s),
        .o_br_lt (lt_s)
    );

    assign dec_s = br_decode(op_s, lt_s, eq_s);

    // Response slot and round-robin pointer
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rsp_valid_r <= 1'b0;
            rsp_taken_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_id_r    <= '0;
            rsp_tag_r   <= '0;
            rr_ptr_r    <= '0;
        end else if (any_gnt_s) begin
            rsp_valid_r <= 1'b1;
            rsp_taken_r <= dec_s[1];
            rsp_err_r   <= dec_s[0];
            rsp_id_r    <= gnt_idx_s;
            rsp_tag_r   <= tag_s;
            if (gnt_idx_s == IDX_W'(NUM_REQ-1)) begin
                rr_ptr_r <= '0;
            end else begin
                rr_ptr_r <= gnt_idx_s + IDX_W'(1);
            end
        end else if (i_rsp_ready) begin
            rsp_valid_r <= 1'b0;
        end
    end

    assign o_rsp_valid = rsp_valid_r;
    assign o_rsp_taken = rsp_taken_r;
    assign o_rsp_err   = rsp_err_r;
    assign o_rsp_id    = rsp_id_r;
    assign o_rsp_tag   = rsp_tag_r;

`ifdef BRC_ARB_STATS_EN
    logic [15:0] grant_cnt_r [NUM_REQ];
    logic [15:0] stall_cnt_r;

    // Saturating per-requester grant counters
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < NUM_REQ; k++) grant_cnt_r[k] <= 16'h0000;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (gnt_s[k] && grant_cnt_r[k] != 16'hFFFF) begin
                    grant_cnt_r[k] <= grant_cnt_r[k] + 16'd1;
                end
            end
        end
    end

    // Saturating count of cycles where a request was blocked by a full slot
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stall_cnt_r <= 16'h0000;
        end else if ((|i_req_valid) && !can_acc_s && stall_cnt_r != 16'hFFFF) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
        assign o_grant_cnt[g*16 +: 16] = grant_cnt_r[g];
    end
    assign o_stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_brc_arbiter.sv
// Directed self-checking bench for brc_arbiter (NUM_REQ=2, TAG_W=4).
module tb_brc_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_rs1;
    logic [63:0] req_rs2;
    logic [5:0]  req_op;
    logic [7:0]  req_tag;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [3:0]  rsp_tag;
    logic        rsp_taken;
    logic        rsp_err;
`ifdef BRC_ARB_STATS_EN
    logic [31:0] grant_cnt;
    logic [15:0] stall_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    brc_arbiter #(.NUM_REQ(2), .TAG_W(4)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_rs1   (req_rs1),
        .i_req_rs2   (req_rs2),
        .i_req_op    (req_op),
        .i_req_tag   (req_tag),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_id    (rsp_id),
        .o_rsp_tag   (rsp_tag),
        .o_rsp_taken (rsp_taken),
`ifdef BRC_ARB_STATS_EN
        .o_grant_cnt (grant_cnt),
        .o_stall_cnt (stall_cnt),
`endif
        .o_rsp_err   (rsp_err)
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op, input logic [3:0] tag);
        req_rs1[k*32 +: 32] = a;
        req_rs2[k*32 +: 32] = b;
        req_op[k*3 +: 3]    = op;
        req_tag[k*4 +: 4]   = tag;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 2'b11;
        req_rs1   = '0;
        req_rs2   = '0;
        req_op    = '0;
        req_tag   = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_taken", 32'(rsp_taken), 32'd0);
        check("rst_err",   32'(rsp_err),   32'd0);
        check("rst_id",    32'(rsp_id),    32'd0);
        check("rst_tag",   32'(rsp_tag),   32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
`ifdef BRC_ARB_STATS_EN
        check("rst_gcnt", grant_cnt, 32'd0);
        check("rst_scnt", 32'(stall_cnt), 32'd0);
`endif
        rst       = 1'b0;
        req_valid = 2'b00;
        tick();

        // BLT: -5 < 3 signed
        set_req(0, 32'hFFFFFFFB, 32'd3, 3'b100, 4'h1);
        req_valid = 2'b01;
        #1 check("blt_ready", 32'(req_ready), 32'd1);
        tick();
        check("blt_valid", 32'(rsp_valid), 32'd1);
        check("blt_id",    32'(rsp_id),    32'd0);
        check("blt_taken", 32'(rsp_taken), 32'd1);
        check("blt_err",   32'(rsp_err),   32'd0);
        check("blt_tag",   32'(rsp_tag),   32'd1);

        // BLTU: 0xFFFFFFFB < 3 unsigned is false; ptr=1 wraps back to req0
        set_req(0, 32'hFFFFFFFB, 32'd3, 3'b110, 4'h2);
        #1 check("bltu_ready", 32'(req_ready), 32'd1);
        tick();
        check("bltu_taken", 32'(rsp_taken), 32'd0);
        check("bltu_tag",   32'(rsp_tag),   32'd2);

        set_req(0, 32'hFFFFFFFB, 32'd3, 3'b111, 4'h3);
        tick();
        check("bgeu_taken", 32'(rsp_taken), 32'd1);

        // Illegal funct3 from req1 is still granted and consumed
        set_req(1, 32'd7, 32'd7, 3'b010, 4'hA);
        req_valid = 2'b10;
        #1 check("ill_ready", 32'(req_ready), 32'd2);
        tick();
        check("ill_valid", 32'(rsp_valid), 32'd1);
        check("ill_id",    32'(rsp_id),    32'd1);
        check("ill_err",   32'(rsp_err),   32'd1);
        check("ill_taken", 32'(rsp_taken), 32'd0);
        check("ill_tag",   32'(rsp_tag),   32'hA);

        // Both requesters continuously valid: strict alternation from req0
        set_req(0, 32'd5, 32'd5, 3'b000, 4'h2);
        set_req(1, 32'd5, 32'd5, 3'b001, 4'h3);
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1 check("alt_ready", 32'(req_ready), (i % 2 == 0) ? 32'd1 : 32'd2);
            tick();
            check("alt_valid", 32'(rsp_valid), 32'd1);
            check("alt_id",    32'(rsp_id),    32'(i % 2));
            check("alt_tag",   32'(rsp_tag),   (i % 2 == 0) ? 32'd2 : 32'd3);
            check("alt_taken", 32'(rsp_taken), (i % 2 == 0) ? 32'd1 : 32'd0);
        end

        // Backpressure: pending id1 response must hold, no grants
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check("bp_ready", 32'(req_ready), 32'd0);
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_id",    32'(rsp_id),    32'd1);
            check("bp_tag",   32'(rsp_tag),   32'd3);
            tick();
        end
`ifdef BRC_ARB_STATS_EN
        check("stall_cnt", 32'(stall_cnt), 32'd3);
`endif
        // Release: drain and accept in the same edge
        rsp_ready = 1'b1;
        #1 check("rel_ready", 32'(req_ready), 32'd1);
        tick();
        check("rel_valid", 32'(rsp_valid), 32'd1);
        check("rel_id",    32'(rsp_id),    32'd0);
        check("rel_tag",   32'(rsp_tag),   32'd2);

        req_valid = 2'b00;
        tick();
        check("drain_valid", 32'(rsp_valid), 32'd0);
        check("drain_tag",   32'(rsp_tag),   32'd2);

        // Reset while a response is pending; pointer would otherwise favour req0 anyway,
        // so leave it at req1's turn first by granting req0.
        req_valid = 2'b01;
        tick();
        req_valid = 2'b11;
        check("pre_rst_valid", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        #1 check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd0);
`ifdef BRC_ARB_STATS_EN
        check("mid_rst_gcnt", grant_cnt, 32'd0);
        check("mid_rst_scnt", 32'(stall_cnt), 32'd0);
`endif
        tick();
        rst = 1'b0;
        #1 check("post_rst_ready", 32'(req_ready), 32'd1);
        tick();
        check("post_rst_valid", 32'(rsp_valid), 32'd1);
        check("post_rst_id",    32'(rsp_id),    32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
